result_display_driver: RTL and testbench

- Downstream stage of the ALU datapath. Takes one registered ALU result and shows it in decimal on the board's 4-digit common-anode 7-segment display.
- Converts the result from binary to BCD sequentially (shift-add-3, one bit per cycle), with optional two's-complement sign handling.
- Time-multiplexes sign, hundreds, tens and units onto sseg/an, with leading-zero blanking.
- Replaces the ALU's direct hex digit output. Its output is consumed only by the display pins.

---
 rtl/result_display_driver.sv | 205 ++++++++++++++++++++
 tb/tb_result_display_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_display_driver.sv
// result_display_driver
// Shows one ALU result in decimal on a 4-digit common-anode 7-segment display.
// The binary result is converted to BCD with the shift-add-3 method, one bit per
// clock, with optional two's-complement sign handling. The held digits are then
// time-multiplexed onto the display as sign, hundreds, tens and units, with
// leading-zero blanking. The display keeps showing the previous value until a
// conversion completes.
module result_display_driver #(
    parameter int DATA_W      = 8,      // result width, 4..9 (at most 3 decimal digits)
    parameter int REFRESH_DIV = 50000   // clk cycles per lit digit, at least 2
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic [DATA_W-1:0] data_in,
    input  logic              is_signed,
    input  logic              valid,
    output logic              ready,
    output logic [0:6]        sseg,       // a..g, active-low, sseg[0] = a
    output logic [3:0]        an          // active-low: 0 units, 1 tens, 2 hundreds, 3 sign
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCD_W  = 12;                 // three BCD nibbles
    localparam int WORD_W = BCD_W + DATA_W;     // {bcd, magnitude} shift word

    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BITS_INIT = CNT_W'(DATA_W);

    // FSM encoding
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_CONVERT = 1'b1;

    // Segment patterns (abcdefg, active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Shift-add-3 correction for one BCD nibble: a nibble of 5 or more would
    // overflow past 9 after the next doubling, so it is pre-biased by 3.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Decimal digit to active-low segment pattern; non-decimal codes blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] pat;
        case (d)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        state;
    logic [DATA_W-1:0] mag;           // magnitude still to be shifted in
    logic [BCD_W-1:0]  bcd;           // BCD accumulator
    logic [CNT_W-1:0]  bit_cnt;       // conversion iterations remaining
    logic              neg_pending;   // sign of the value being converted

    logic [3:0]        hundreds;      // digits currently on the display
    logic [3:0]        tens;
    logic [3:0]        units;
    logic              neg;

    logic [REF_W-1:0]  ref_cnt;       // dwell counter for the lit digit
    logic [1:0]        digit_idx;     // 0 units, 1 tens, 2 hundreds, 3 sign

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic              accept;
    logic              take_neg;
    logic [DATA_W:0]   neg_wide;
    logic [DATA_W-1:0] load_mag;
    logic [BCD_W-1:0]  bcd_adj;
    logic [WORD_W-1:0] shift_word;
    logic [BCD_W-1:0]  bcd_next;
    logic [DATA_W-1:0] mag_next;
    logic              last_iter;

    assign ready  = (state == S_IDLE);
    assign accept = valid && ready;

    // Negation is done one bit wider so the most negative input (e.g. -128)
    // yields its true magnitude, which still fits in DATA_W unsigned bits.
    assign take_neg = is_signed && data_in[DATA_W-1];
    assign neg_wide = -{data_in[DATA_W-1], data_in};
    assign load_mag = take_neg ? neg_wide[DATA_W-1:0] : data_in;

    assign bcd_adj    = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    assign shift_word = {bcd_adj, mag} << 1;
    assign bcd_next   = shift_word[DATA_W +: BCD_W];
    assign mag_next   = shift_word[DATA_W-1:0];
    assign last_iter  = (bit_cnt == CNT_W'(1));

    // ------------------------------------------------------------------
    // Conversion FSM: accept a request, then run DATA_W shift-add-3 steps
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mag         <= '0;
            bcd         <= '0;
            bit_cnt     <= '0;
            neg_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mag         <= load_mag;
                        neg_pending <= take_neg;
                        bcd         <= '0;
                        bit_cnt     <= BITS_INIT;
                        state       <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd     <= bcd_next;
                    mag     <= mag_next;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (last_iter) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Held display digits: loaded only on the final conversion step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hundreds <= 4'd0;
            tens     <= 4'd0;
            units    <= 4'd0;
            neg      <= 1'b0;
        end else if (state == S_CONVERT && last_iter) begin
            hundreds <= bcd_next[11:8];
            tens     <= bcd_next[7:4];
            units    <= bcd_next[3:0];
            neg      <= neg_pending;
        end
    end

    // Refresh scan: free-running dwell counter advances the digit index on wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt   <= '0;
            digit_idx <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            ref_cnt   <= ref_cnt + REF_W'(1);
        end
    end

    // Digit select and segment decode with leading-zero blanking
    // NOTE: both outputs get a default first so no path through the case can
    // leave them unassigned and infer a latch.
    always_comb begin
        an   = 4'b1111;
        sseg = SEG_BLANK;
        case (digit_idx)
            2'd0: begin
                an   = 4'b1110;
                sseg = seg_digit(units);
            end
            2'd1: begin
                an   = 4'b1101;
                sseg = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_digit(tens);
            end
            2'd2: begin
                an   = 4'b1011;
                sseg = (hundreds == 4'd0) ? SEG_BLANK : seg_digit(hundreds);
            end
            default: begin
                an   = 4'b0111;
                sseg = neg ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_result_display_driver.sv
// Self-checking bench for result_display_driver (DATA_W=8, REFRESH_DIV=4).
// A decimal reference model (value, sign, scan position derived from the cycle
// count since reset) predicts an, sseg and ready at every falling edge.
module tb_result_display_driver;

    localparam int DATA_W      = 8;
    localparam int REFRESH_DIV = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              is_signed;
    logic              valid;
    logic              ready;
    logic [0:6]        sseg;
    logic [3:0]        an;

    int errors = 0;
    int checks = 0;

    // Reference model: the value currently on the display
    int m_val = 0;
    bit m_neg = 1'b0;

    // Rising edges seen since reset was released (drives the scan model)
    int cycles;

    result_display_driver #(
        .DATA_W      (DATA_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .is_signed (is_signed),
        .valid     (valid),
        .ready     (ready),
        .sseg      (sseg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cycles <= 0;
        else      cycles <= cycles + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected scan output from the model value and the scan position
    task automatic check_display(input string tag);
        int         idx;
        int         h;
        int         t;
        int         u;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        idx     = (cycles / REFRESH_DIV) % 4;
        h       = m_val / 100;
        t       = (m_val / 10) % 10;
        u       = m_val % 10;
        exp_an  = ~(4'b0001 << idx);
        case (idx)
            0:       exp_seg = seg_of(u);
            1:       exp_seg = (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
            2:       exp_seg = (h == 0) ? 7'b1111111 : seg_of(h);
            default: exp_seg = m_neg ? 7'b1111110 : 7'b1111111;
        endcase
        check({tag, " an"}, 32'(an), 32'(exp_an));
        check({tag, " sseg"}, 32'(sseg), 32'(exp_seg));
    endtask

    task automatic set_model(input logic [7:0] v, input logic s);
        if (s && v[7]) begin
            m_val = 256 - int'(v);
            m_neg = 1'b1;
        end else begin
            m_val = int'(v);
            m_neg = 1'b0;
        end
    endtask

    // One request: ready low 8 cycles with the old value shown, then new value
    task automatic send(input logic [7:0] v, input logic s, input string tag);
        @(negedge clk);
        check({tag, " ready before"}, 32'(ready), 32'd1);
        data_in   = v;
        is_signed = s;
        valid     = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check({tag, " ready busy"}, 32'(ready), 32'd0);
            check_display({tag, " old"});
        end
        set_model(v, s);
        @(negedge clk);
        check({tag, " ready done"}, 32'(ready), 32'd1);
        check_display({tag, " new"});
    endtask

    // Watch a full scan of all four digits
    task automatic scan(input string tag);
        for (int i = 0; i < 4 * REFRESH_DIV; i++) begin
            @(negedge clk);
            check_display(tag);
        end
    endtask

    initial begin
        logic [7:0] rv;
        logic       rs;

        rst       = 1'b0;
        data_in   = '0;
        is_signed = 1'b0;
        valid     = 1'b0;

        // Reset values while held
        #3;
        check("reset an", 32'(an), 32'(4'b1110));
        check("reset sseg", 32'(sseg), 32'(7'b0000001));
        check("reset ready", 32'(ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle scan of "0"
        scan("idle scan");

        // Unsigned three-digit value
        send(8'd200, 1'b0, "u200");
        scan("u200 scan");

        // Small negative: -2
        send(8'hFE, 1'b1, "s-2");
        scan("s-2 scan");

        // Most negative: -128
        send(8'h80, 1'b1, "s-128");
        scan("s-128 scan");

        // Valid during conversion is ignored, no queueing
        @(negedge clk);
        data_in   = 8'd5;
        is_signed = 1'b0;
        valid     = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                data_in = 8'd7;
                valid   = 1'b1;
            end
            if (i == 2) valid = 1'b0;
            check("ign ready busy", 32'(ready), 32'd0);
            check_display("ign old");
        end
        set_model(8'd5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ign ready idle", 32'(ready), 32'd1);
            check_display("ign new");
        end

        // Valid held high: re-acceptance on the first edge back in IDLE
        @(negedge clk);
        data_in   = 8'd99;
        is_signed = 1'b0;
        valid     = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                data_in   = 8'hF6;   // -10 when signed
                is_signed = 1'b1;
            end
            check("hold ready busy1", 32'(ready), 32'd0);
            check_display("hold old");
        end
        set_model(8'd99, 1'b0);
        @(negedge clk);
        check("hold ready gap", 32'(ready), 32'd1);
        check_display("hold first");
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) valid = 1'b0;
            check("hold ready busy2", 32'(ready), 32'd0);
            check_display("hold first");
        end
        set_model(8'hF6, 1'b1);
        @(negedge clk);
        check("hold ready done", 32'(ready), 32'd1);
        scan("hold second scan");

        // Randomized values against the decimal model
        for (int n = 0; n < 12; n++) begin
            rv = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            send(rv, rs, "rand");
            for (int i = 0; i < $urandom_range(1, 8); i++) begin
                @(negedge clk);
                check_display("rand scan");
            end
        end

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        data_in   = 8'd250;
        is_signed = 1'b0;
        valid     = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        m_val = 0;
        m_neg = 1'b0;
        #1;
        check("midrst an", 32'(an), 32'(4'b1110));
        check("midrst sseg", 32'(sseg), 32'(7'b0000001));
        check("midrst ready", 32'(ready), 32'd1);
        @(negedge clk);
        check_display("midrst held");
        @(negedge clk);
        rst = 1'b1;
        scan("post reset scan");
        send(8'd42, 1'b0, "u42");
        scan("u42 scan");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
